// File: rtl/fir_filter_if.sv
// Sample stream bundle between a source (master) and the FIR filter (slave).
interface fir_filter_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] y_out;

  modport master (output x_in, input  y_out);
  modport slave  (input  x_in, output y_out);
endinterface

// File: rtl/fir_filter.sv
// 8-tap symmetric Q1.15 low-pass FIR, one sample per clock, registered saturating output.
// Macro FIR_ROUND_EN selects round-half-up scaling; undefined, the product sum is truncated.
module fir_filter #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int N_TAPS    = 8,
  parameter int FRAC_BITS = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  fir_filter_if.slave bus
);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(N_TAPS);

  // Coefficients sum to 32768, i.e. exactly 1.0 in Q1.15 (unity DC gain).
  localparam logic signed [COEF_W-1:0] COEF [N_TAPS] = '{
    COEF_W'(1024), COEF_W'(2048), COEF_W'(4096), COEF_W'(9216),
    COEF_W'(9216), COEF_W'(4096), COEF_W'(2048), COEF_W'(1024)
  };

  localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(2 ** (FRAC_BITS - 1));
  localparam logic signed [ACC_W:0] Y_MAX = (ACC_W+1)'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W:0] Y_MIN = (ACC_W+1)'(-(2 ** (DATA_W - 1)));

  logic signed [DATA_W-1:0] x_d_q [N_TAPS];
  logic signed [ACC_W-1:0]  prod  [N_TAPS];
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W:0]    scaled_d;
  logic signed [DATA_W-1:0] y_d;
  logic signed [DATA_W-1:0] y_q;

  for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
    assign prod[gi] = ACC_W'(x_d_q[gi]) * ACC_W'(COEF[gi]);
  end

  always_comb begin
    acc_d = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      acc_d = acc_d + prod[i];
    end
  end

  // One guard bit above the accumulator keeps the rounding offset from overflowing.
  always_comb begin
`ifdef FIR_ROUND_EN
    scaled_d = ((ACC_W+1)'(acc_d) + HALF) >>> FRAC_BITS;
`else
    scaled_d = (ACC_W+1)'(acc_d) >>> FRAC_BITS;
`endif
    y_d = scaled_d[DATA_W-1:0];
    if (scaled_d > Y_MAX) begin
      y_d = Y_MAX[DATA_W-1:0];
    end else if (scaled_d < Y_MIN) begin
      y_d = Y_MIN[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) begin
        x_d_q[i] <= '0;
      end
      y_q <= '0;
    end else begin
      x_d_q[0] <= bus.x_in;
      for (int i = 1; i < N_TAPS; i++) begin
        x_d_q[i] <= x_d_q[i-1];
      end
      y_q <= y_d;
    end
  end

  assign bus.y_out = y_q;
endmodule

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: a convolution model queues expected outputs, tasks pop and compare.
module tb_fir_filter;
`ifdef FIR_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif
  localparam int C [8] = '{1024, 2048, 4096, 9216, 9216, 4096, 2048, 1024};

  logic clk = 1'b0;
  logic rst_n;
  fir_filter_if #(.DATA_W(16)) bus ();

  fir_filter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cmp_count = 0;
  int err_count = 0;
  int hist [8];
  int exp_q [$];

  // Independent reference: floor((sum + optional half) / 2^15), then clamp.
  function automatic int model_out();
    longint acc;
    acc = 0;
    for (int i = 0; i < 8; i++) acc += longint'(C[i]) * longint'(hist[i]);
    if (ROUND) acc += 16384;
    acc = acc >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 8; i++) hist[i] = 0;
    exp_q.delete();
    exp_q.push_back(0);
  endfunction

  // Present one sample, let it be captured, and queue the output the next edge must produce.
  task automatic drive(input int x);
    bus.x_in = 16'(x);
    @(posedge clk);
    #1;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    exp_q.push_back(model_out());
  endtask

  task automatic test_reset();
    logic signed [15:0] e;
    rst_n = 1'b0;
    bus.x_in = 16'sd20000;
    repeat (4) begin
      @(posedge clk);
      #1;
      cmp_count++;
      if (bus.y_out !== 16'sd0) begin
        err_count++;
        $display("FAIL reset_hold y_out=%0d required=0", bus.y_out);
      end else $display("ok reset_hold y_out=%0d", bus.y_out);
    end
    #2 rst_n = 1'b1;
    clear_model();
    repeat (8) begin
      drive(0);
      e = 16'(exp_q.pop_front());
      cmp_count++;
      if (bus.y_out !== e || e !== 16'sd0) begin
        err_count++;
        $display("FAIL reset_line_clear y_out=%0d required=0", bus.y_out);
      end else $display("ok reset_line_clear y_out=%0d", bus.y_out);
    end
  endtask

  task automatic test_impulse();
    int imp [9] = '{625, 1250, 2500, 5625, 5625, 2500, 1250, 625, 0};
    logic signed [15:0] e;
    drive(20000);
    e = 16'(exp_q.pop_front());
    cmp_count++;
    if (bus.y_out !== e) begin
      err_count++;
      $display("FAIL impulse_sb y_out=%0d required=%0d", bus.y_out, e);
    end else $display("ok impulse_sb x=20000 y_out=%0d", bus.y_out);
    for (int k = 0; k < 9; k++) begin
      drive(0);
      e = 16'(exp_q.pop_front());
      cmp_count += 2;
      if (bus.y_out !== e) begin
        err_count++;
        $display("FAIL impulse_sb[%0d] y_out=%0d required=%0d", k, bus.y_out, e);
      end
      if (bus.y_out !== 16'(imp[k])) begin
        err_count++;
        $display("FAIL impulse_tab[%0d] y_out=%0d required=%0d", k, bus.y_out, imp[k]);
      end else $display("ok impulse[%0d] y_out=%0d", k, bus.y_out);
    end
  endtask

  task automatic test_step();
    int st [8] = ROUND ? '{313, 938, 2188, 5000, 7813, 9063, 9688, 10000}
                       : '{312, 937, 2187, 5000, 7812, 9062, 9687, 10000};
    int want;
    logic signed [15:0] e;
    for (int k = 0; k < 16; k++) begin
      drive(10000);
      e = 16'(exp_q.pop_front());
      want = (k == 0) ? 0 : ((k <= 8) ? st[k-1] : 10000);
      cmp_count += 2;
      if (bus.y_out !== e) begin
        err_count++;
        $display("FAIL step_sb[%0d] y_out=%0d required=%0d", k, bus.y_out, e);
      end
      if (bus.y_out !== 16'(want)) begin
        err_count++;
        $display("FAIL step_tab[%0d] y_out=%0d required=%0d", k, bus.y_out, want);
      end else $display("ok step[%0d] y_out=%0d", k, bus.y_out);
    end
    for (int k = 0; k < 9; k++) begin
      drive(0);
      e = 16'(exp_q.pop_front());
      want = (k == 0) ? 10000 : ((k < 8) ? st[7-k] : 0);
      cmp_count += 2;
      if (bus.y_out !== e) begin
        err_count++;
        $display("FAIL decay_sb[%0d] y_out=%0d required=%0d", k, bus.y_out, e);
      end
      if (bus.y_out !== 16'(want)) begin
        err_count++;
        $display("FAIL decay_tab[%0d] y_out=%0d required=%0d", k, bus.y_out, want);
      end else $display("ok decay[%0d] y_out=%0d", k, bus.y_out);
    end
  endtask

  task automatic test_round_mode();
    logic signed [15:0] e;
    logic signed [15:0] want;
    want = ROUND ? -16'sd312 : -16'sd313;
    drive(-10000);
    void'(exp_q.pop_front());
    drive(0);
    e = 16'(exp_q.pop_front());
    cmp_count += 2;
    if (bus.y_out !== e) begin
      err_count++;
      $display("FAIL round_sb y_out=%0d required=%0d", bus.y_out, e);
    end
    if (bus.y_out !== want) begin
      err_count++;
      $display("FAIL round_first y_out=%0d required=%0d", bus.y_out, want);
    end else $display("ok round_first y_out=%0d", bus.y_out);
    repeat (8) begin
      drive(0);
      e = 16'(exp_q.pop_front());
      cmp_count++;
      if (bus.y_out !== e) begin
        err_count++;
        $display("FAIL round_tail y_out=%0d required=%0d", bus.y_out, e);
      end else $display("ok round_tail y_out=%0d", bus.y_out);
    end
  endtask

  task automatic test_extremes();
    int lvl [2] = '{-32768, 32767};
    logic signed [15:0] e;
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 10; k++) begin
        drive(lvl[j]);
        e = 16'(exp_q.pop_front());
        cmp_count++;
        if (bus.y_out !== e) begin
          err_count++;
          $display("FAIL extreme_sb[%0d] y_out=%0d required=%0d", k, bus.y_out, e);
        end else $display("ok extreme x=%0d y_out=%0d", lvl[j], bus.y_out);
      end
      cmp_count++;
      if (bus.y_out !== 16'(lvl[j])) begin
        err_count++;
        $display("FAIL extreme_settle y_out=%0d required=%0d", bus.y_out, lvl[j]);
      end
    end
  endtask

  task automatic test_random_stream();
    int x;
    logic signed [15:0] e;
    repeat (40) begin
      x = int'($urandom_range(65535)) - 32768;
      drive(x);
      e = 16'(exp_q.pop_front());
      cmp_count++;
      if (bus.y_out !== e) begin
        err_count++;
        $display("FAIL random_sb x=%0d y_out=%0d required=%0d", x, bus.y_out, e);
      end else $display("ok random x=%0d y_out=%0d", x, bus.y_out);
    end
  endtask

  task automatic test_midstream_reset();
    logic signed [15:0] e;
    logic signed [15:0] first;
    first = ROUND ? 16'sd313 : 16'sd312;
    repeat (5) begin
      drive(10000);
      void'(exp_q.pop_front());
    end
    #2 rst_n = 1'b0;
    #1;
    cmp_count++;
    if (bus.y_out !== 16'sd0) begin
      err_count++;
      $display("FAIL midreset_async y_out=%0d required=0", bus.y_out);
    end else $display("ok midreset_async y_out=%0d", bus.y_out);
    #2 rst_n = 1'b1;
    clear_model();
    for (int k = 0; k < 10; k++) begin
      drive(10000);
      e = 16'(exp_q.pop_front());
      cmp_count++;
      if (bus.y_out !== e) begin
        err_count++;
        $display("FAIL midreset_sb[%0d] y_out=%0d required=%0d", k, bus.y_out, e);
      end else $display("ok midreset[%0d] y_out=%0d", k, bus.y_out);
      if (k == 1) begin
        cmp_count++;
        if (bus.y_out !== first) begin
          err_count++;
          $display("FAIL midreset_restart y_out=%0d required=%0d", bus.y_out, first);
        end
      end
    end
  endtask

  initial begin
    bus.x_in = '0;
    test_reset();
    test_impulse();
    test_step();
    test_round_mode();
    test_extremes();
    test_random_stream();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end
endmodule
